im_fetch_arbiter: RTL and testbench

- Fetch controller and read-port arbiter for the 128-byte, byte-addressed, big-endian instruction memory.
- Owns the PC and issues word fetches to the memory's single combinational read port. Presents registered instructions to decode over a valid/ready handshake.
- Shares the same read port with a debug/testbench read requester.
- Sits between the instruction memory and the decode stage of the simple CPU.

---
 rtl/im_fetch_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_im_fetch_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : im_fetch_arbiter
// Description : Fetch controller and read-port arbiter for the 128-byte,
//               byte-addressed, big-endian instruction memory. Owns the PC,
//               issues word fetches on the memory's single combinational read
//               port and presents registered instructions to decode over a
//               valid/ready handshake. A debug read requester shares the same
//               port under round-robin arbitration.
//
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               im_addr/im_instr  - instruction memory read port
//               f_valid/f_ready/f_instr/f_pc - fetched instruction to decode
//               redir_valid/redir_pc         - branch/jump redirect
//               dbg_req/dbg_addr/dbg_gnt     - debug read request / grant
//               dbg_rvalid/dbg_rdata         - debug read response
//               halted/err        - fetch stopped / stopped by misaligned redirect
//
// Options     : IM_ARB_STATS_EN - when defined, adds stat_fetch_cnt and
//               stat_conflict_cnt saturating 16-bit counters.
//
// Revision    : 1.0 - initial release
// ============================================================================
module im_fetch_arbiter #(
    parameter int unsigned MEM_SIZE = 128,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        halted,
    output logic        err
`ifdef IM_ARB_STATS_EN
    ,
    output logic [15:0] stat_fetch_cnt,
    output logic [15:0] stat_conflict_cnt
`endif
);

    // Highest byte address at which a full word can still be read.
    localparam logic [31:0] C_LAST_WORD = 32'(MEM_SIZE - 4);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic        r_f_valid;
    logic [31:0] r_f_instr;
    logic [31:0] r_f_pc;
    logic        r_dbg_rvalid;
    logic [31:0] r_dbg_rdata;
    logic        r_err;
    // 1 when debug won the most recent conflict; starts at 1 so fetch wins first.
    logic        r_last_dbg;

    logic        w_fetch_want;
    logic        w_pc_oob;
    logic        w_fetch_req;
    logic        w_dbg_oob;
    logic        w_conflict;
    logic        w_dbg_gnt;
    logic        w_fetch_gnt;
    logic [31:0] w_im_addr;

    // ------------------------------------------------------------------------
    // Next-state and arbitration
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_fetch_want = 1'b0;
        w_pc_oob     = 1'b0;
        w_fetch_req  = 1'b0;
        w_dbg_oob    = 1'b0;
        w_conflict   = 1'b0;
        w_dbg_gnt    = 1'b0;
        w_fetch_gnt  = 1'b0;
        w_im_addr    = r_pc;

        // Fetch only when the output slot is free or being drained, and never
        // in a cycle that carries a redirect (the old stream is being flushed).
        w_fetch_want = (r_state == S_RUN) && (!r_f_valid || f_ready) && !redir_valid;
        w_pc_oob     = (r_pc > C_LAST_WORD);
        w_fetch_req  = w_fetch_want && !w_pc_oob;
        w_dbg_oob    = (dbg_addr > C_LAST_WORD);

        w_conflict   = w_fetch_req && dbg_req;
        // Round-robin: on conflict the side that did not win last time wins.
        w_dbg_gnt    = dbg_req && (!w_fetch_req || !r_last_dbg);
        w_fetch_gnt  = w_fetch_req && !w_dbg_gnt;

        if (w_dbg_gnt) begin
            w_im_addr = w_dbg_oob ? 32'h0 : dbg_addr;
        end

        if (redir_valid) begin
            w_state_nxt = (redir_pc[1:0] == 2'b00) ? S_RUN : S_HALT;
        end else if (w_fetch_want && w_pc_oob) begin
            // Ran off the end of memory: stop without issuing the access.
            w_state_nxt = S_HALT;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_f_valid    <= 1'b0;
            r_f_instr    <= 32'h0;
            r_f_pc       <= 32'h0;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= 32'h0;
            r_err        <= 1'b0;
            r_last_dbg   <= 1'b1;
        end else begin
            r_dbg_rvalid <= w_dbg_gnt;
            if (w_dbg_gnt) begin
                // An out-of-range debug read drives address 0 on the port, so
                // the returned data must be forced to zero rather than sampled.
                r_dbg_rdata <= w_dbg_oob ? 32'h0 : im_instr;
            end

            if (w_conflict) begin
                r_last_dbg <= w_dbg_gnt;
            end

            if (redir_valid) begin
                r_pc      <= redir_pc;
                r_f_valid <= 1'b0;
                r_err     <= (redir_pc[1:0] != 2'b00);
            end else if (w_fetch_gnt) begin
                r_f_instr <= im_instr;
                r_f_pc    <= r_pc;
                r_f_valid <= 1'b1;
                r_pc      <= r_pc + 32'd4;
            end else if (r_f_valid && f_ready) begin
                r_f_valid <= 1'b0;
            end
        end
    end

`ifdef IM_ARB_STATS_EN
    logic [15:0] r_stat_fetch;
    logic [15:0] r_stat_conflict;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_fetch    <= 16'h0;
            r_stat_conflict <= 16'h0;
        end else begin
            if (r_f_valid && f_ready && (r_stat_fetch != 16'hFFFF)) begin
                r_stat_fetch <= r_stat_fetch + 16'd1;
            end
            if (w_conflict && (r_stat_conflict != 16'hFFFF)) begin
                r_stat_conflict <= r_stat_conflict + 16'd1;
            end
        end
    end

    assign stat_fetch_cnt    = r_stat_fetch;
    assign stat_conflict_cnt = r_stat_conflict;
`endif

    assign im_addr    = w_im_addr;
    assign f_valid    = r_f_valid;
    assign f_instr    = r_f_instr;
    assign f_pc       = r_f_pc;
    assign dbg_gnt    = w_dbg_gnt;
    assign dbg_rvalid = r_dbg_rvalid;
    assign dbg_rdata  = r_dbg_rdata;
    assign halted     = (r_state == S_HALT);
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_im_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_fetch_arbiter
// Description : Self-checking bench for im_fetch_arbiter. A byte-array memory
//               model feeds the read port; a reference model of the fetch
//               stream, debug responses and arbitration predicts every output
//               each cycle. Directed sequences are followed by randomized
//               traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_fetch_arbiter;

    localparam int unsigned MEM_SIZE = 128;
    localparam logic [31:0] C_LAST   = 32'(MEM_SIZE - 4);

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_rst_n = 1'b0;
    logic        r_f_ready = 1'b0;
    logic        r_redir_valid = 1'b0;
    logic [31:0] r_redir_pc = 32'h0;
    logic        r_dbg_req = 1'b0;
    logic [31:0] r_dbg_addr = 32'h0;
    logic [31:0] r_im_instr;

    logic [31:0] w_im_addr;
    logic        w_f_valid;
    logic [31:0] w_f_instr;
    logic [31:0] w_f_pc;
    logic        w_dbg_gnt;
    logic        w_dbg_rvalid;
    logic [31:0] w_dbg_rdata;
    logic        w_halted;
    logic        w_err;
`ifdef IM_ARB_STATS_EN
    logic [15:0] w_stat_fetch;
    logic [15:0] w_stat_conflict;
`endif

    im_fetch_arbiter #(
        .MEM_SIZE (MEM_SIZE),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk         (clk),
        .rst_n       (r_rst_n),
        .im_addr     (w_im_addr),
        .im_instr    (r_im_instr),
        .f_valid     (w_f_valid),
        .f_ready     (r_f_ready),
        .f_instr     (w_f_instr),
        .f_pc        (w_f_pc),
        .redir_valid (r_redir_valid),
        .redir_pc    (r_redir_pc),
        .dbg_req     (r_dbg_req),
        .dbg_addr    (r_dbg_addr),
        .dbg_gnt     (w_dbg_gnt),
        .dbg_rvalid  (w_dbg_rvalid),
        .dbg_rdata   (w_dbg_rdata),
        .halted      (w_halted),
        .err         (w_err)
`ifdef IM_ARB_STATS_EN
        ,
        .stat_fetch_cnt    (w_stat_fetch),
        .stat_conflict_cnt (w_stat_conflict)
`endif
    );

    // ------------------------------------------------------------------------
    // Instruction memory: byte array, big-endian words, combinational read.
    // ------------------------------------------------------------------------
    logic [7:0] mem_b [0:MEM_SIZE-1];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] v;
        logic [31:0] ba;
        v = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ba = a + 32'(i);
            v  = v << 8;
            if (ba < MEM_SIZE) v[7:0] = mem_b[ba[6:0]];
        end
        return v;
    endfunction

    always_comb r_im_instr = mem_rd(w_im_addr);

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: what decode holds, where the program counter points,
    // whether fetch has stopped, and what the debug side should see.
    // ------------------------------------------------------------------------
    bit          m_known = 1'b0;
    logic [31:0] m_pc, m_fi, m_fp, m_drd;
    bit          m_fv, m_halt, m_err, m_drv;
    bit          m_dbg_won_last;
    int unsigned m_n_acc, m_n_conf;
    int unsigned m_acc_total = 0;

    task automatic model_reset();
        m_pc = 32'h0; m_fi = 32'h0; m_fp = 32'h0; m_drd = 32'h0;
        m_fv = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_drv = 1'b0;
        m_dbg_won_last = 1'b1;
        m_n_acc = 0; m_n_conf = 0;
        m_known = 1'b1;
    endtask

    // One clock cycle: drive inputs, check, advance the model.
    // o_gnt reports whether the model granted the debug request this cycle.
    task automatic run_cycle(input bit rst_n, input bit fr, input bit rv,
                             input logic [31:0] rpc, input bit dq,
                             input logic [31:0] da, output bit o_gnt);
        bit          slot_free, wants, fetch_ok, both, d_win, f_win;
        logic [31:0] e_addr;

        @(negedge clk);
        r_rst_n       = rst_n;
        r_f_ready     = fr;
        r_redir_valid = rv;
        r_redir_pc    = rpc;
        r_dbg_req     = dq;
        r_dbg_addr    = da;
        #1;

        if (m_known) begin
            check_eq("f_valid",    {31'h0, w_f_valid},    {31'h0, m_fv});
            check_eq("f_instr",    w_f_instr,             m_fi);
            check_eq("f_pc",       w_f_pc,                m_fp);
            check_eq("halted",     {31'h0, w_halted},     {31'h0, m_halt});
            check_eq("err",        {31'h0, w_err},        {31'h0, m_err});
            check_eq("dbg_rvalid", {31'h0, w_dbg_rvalid}, {31'h0, m_drv});
            check_eq("dbg_rdata",  w_dbg_rdata,           m_drd);
`ifdef IM_ARB_STATS_EN
            check_eq("stat_fetch",    {16'h0, w_stat_fetch},    (m_n_acc  > 32'hFFFF) ? 32'hFFFF : m_n_acc);
            check_eq("stat_conflict", {16'h0, w_stat_conflict}, (m_n_conf > 32'hFFFF) ? 32'hFFFF : m_n_conf);
`endif
        end

        slot_free = !m_fv || fr;
        wants     = !m_halt && !rv && slot_free;
        fetch_ok  = wants && (m_pc <= C_LAST);
        both      = fetch_ok && dq;
        d_win     = both ? !m_dbg_won_last : dq;
        f_win     = fetch_ok && !d_win;
        if (d_win)      e_addr = (da <= C_LAST) ? da : 32'h0;
        else            e_addr = m_pc;
        o_gnt = d_win;

        if (m_known && rst_n) begin
            check_eq("dbg_gnt", {31'h0, w_dbg_gnt}, {31'h0, d_win});
            check_eq("im_addr", w_im_addr, e_addr);
        end

        if (!rst_n) begin
            model_reset();
        end else if (m_known) begin
            if (m_fv && fr) begin
                m_n_acc++;
                m_acc_total++;
            end
            if (both) begin
                m_n_conf++;
                m_dbg_won_last = d_win;
            end
            m_drv = d_win;
            if (d_win) m_drd = (da <= C_LAST) ? mem_rd(da) : 32'h0;
            if (rv) begin
                m_pc   = rpc;
                m_fv   = 1'b0;
                m_halt = (rpc[1:0] != 2'b00);
                m_err  = (rpc[1:0] != 2'b00);
            end else begin
                if (wants && !fetch_ok) m_halt = 1'b1;
                if (f_win) begin
                    m_fi = mem_rd(m_pc);
                    m_fp = m_pc;
                    m_fv = 1'b1;
                    m_pc = m_pc + 32'd4;
                end else if (m_fv && fr) begin
                    m_fv = 1'b0;
                end
            end
        end
    endtask

    // Convenience wrappers for directed stretches.
    task automatic idle(input int n, input bit fr);
        bit g;
        for (int i = 0; i < n; i++) run_cycle(1'b1, fr, 1'b0, 32'h0, 1'b0, 32'h0, g);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        bit g;
        run_cycle(1'b1, 1'b1, 1'b1, tgt, 1'b0, 32'h0, g);
    endtask

    // Debug request held until granted, with continuous fetch traffic.
    task automatic dbg_read(input logic [31:0] a);
        bit g;
        g = 1'b0;
        for (int i = 0; i < 8 && !g; i++) run_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, a, g);
        check_eq("dbg_granted", {31'h0, g}, 32'h1);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : main
        bit          g;
        bit          pend;
        logic [31:0] paddr;
        logic [31:0] tgt;
        bit          rv, rst_n;

        for (int k = 0; k < MEM_SIZE / 4; k++) begin
            logic [31:0] w;
            w = (k < 15) ? (32'(k + 1) * 32'h1111_1111) : (32'hC0DE_0000 | 32'(k));
            for (int b = 0; b < 4; b++) mem_b[k*4 + b] = w[31 - 8*b -: 8];
        end

        // Reset, then a straight run to the end of memory.
        run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, g);
        run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, g);
        idle(40, 1'b1);
        check_eq("halt_after_end", {31'h0, w_halted}, 32'h1);
        check_eq("accepted_all",   m_acc_total,       32'd32);

        // Restart and stall decode for three cycles mid-stream.
        redirect(32'h0);
        idle(3, 1'b1);
        idle(3, 1'b0);
        idle(4, 1'b1);

        // Redirect while streaming, misaligned halt, aligned resume.
        redirect(32'h40);
        idle(4, 1'b1);
        redirect(32'h42);
        idle(4, 1'b1);
        check_eq("err_latched", {31'h0, w_err}, 32'h1);
        redirect(32'h0);
        idle(3, 1'b1);

        // Debug reads alternating with fetches, including out-of-range.
        for (int i = 0; i < 4; i++) dbg_read(32'h08);
        dbg_read(32'h7E);
        dbg_read(32'h05);
        idle(1, 1'b1);

        // Reset while a debug response is in flight.
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, g);
        run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, g);
        idle(5, 1'b1);

        // Randomized traffic.
        pend  = 1'b0;
        paddr = 32'h0;
        for (int c = 0; c < 4000; c++) begin
            if (!pend && ($urandom % 3 == 0)) begin
                pend = 1'b1;
                case ($urandom % 4)
                    0:       paddr = 32'h80 + ($urandom % 64);
                    1:       paddr = $urandom % MEM_SIZE;
                    default: paddr = ($urandom % (MEM_SIZE / 4)) * 4;
                endcase
            end
            rv  = ($urandom % 20 == 0);
            case ($urandom % 8)
                0:       tgt = (($urandom % (MEM_SIZE / 4)) * 4) | (1 + $urandom % 3);
                1:       tgt = C_LAST + 4 * (1 + $urandom % 3);
                default: tgt = ($urandom % (MEM_SIZE / 4)) * 4;
            endcase
            rst_n = ($urandom % 500 != 0);
            run_cycle(rst_n, ($urandom % 4 != 0), rv, tgt, pend, paddr, g);
            if (g || !rst_n) pend = 1'b0;
        end
        idle(2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
